// File: rtl/im_fetch_banked_pkg.sv
// Shared definitions for the banked instruction memory.
// Holds the architectural widths, default geometry, the fetch FSM encoding
// and small address helpers. IM_PARITY_EN selects whether each stored word
// carries an extra even-parity bit.
package im_fetch_banked_pkg;

    localparam int ARCH_WIDTH = 32;
    localparam logic [ARCH_WIDTH-1:0] IM_BASE_ADDR = 32'h0000_3000;
    localparam int IM_WIDTH_DEF = 32;
    localparam int IM_DEPTH_DEF = 10;
    localparam int IM_FETCH_WORDS_DEF = 2;

`ifdef IM_PARITY_EN
    localparam int IM_PAR_BITS = 1;
`else
    localparam int IM_PAR_BITS = 0;
`endif

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_e;

    // Word index of a byte address relative to the memory base.
    function automatic logic [ARCH_WIDTH-1:0] word_index(
        input logic [ARCH_WIDTH-1:0] addr,
        input logic [ARCH_WIDTH-1:0] base
    );
        logic [ARCH_WIDTH-1:0] off;
        off = addr - base;
        return off >> 2;
    endfunction

    // Instruction addresses must be word aligned.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/im_fetch_banked_bank.sv
// One bank of the instruction memory: simple dual-port RAM with a single
// write port and a registered read port. A read and a write to the same row
// in one cycle return the previous contents.
module im_fetch_banked_bank #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 512,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [ROW_W-1:0] rd_row_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [ROWS];
    logic [WIDTH-1:0] rd_data_q;

    // Boot-load write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_row_i] <= wr_data_i;
        end
    end

    // Registered read; holds its value while no new fetch is accepted.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_row_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/im_fetch_banked.sv
// Banked synchronous instruction memory returning FETCH_WORDS consecutive
// words per request over a valid/ready handshake, with flush, a boot-load
// write port and alignment/range fault reporting.
// Build option: define IM_PARITY_EN to store an even-parity bit per word
// and report mismatches on rsp_perr/rsp_fault.
module im_fetch_banked
    import im_fetch_banked_pkg::*;
#(
    parameter int IM_WIDTH    = IM_WIDTH_DEF,
    parameter int IM_DEPTH    = IM_DEPTH_DEF,
    parameter int FETCH_WORDS = IM_FETCH_WORDS_DEF,
    parameter logic [ARCH_WIDTH-1:0] BASE_ADDR = IM_BASE_ADDR
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ARCH_WIDTH-1:0]           req_addr,
    input  logic                            flush,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [0:FETCH_WORDS*IM_WIDTH-1] rsp_data,
    output logic                            rsp_fault,
    output logic                            rsp_perr,
    input  logic                            wr_en,
    input  logic [ARCH_WIDTH-1:0]           wr_addr,
    input  logic [0:IM_WIDTH-1]             wr_data
);

    localparam int IM_SIZE = 1 << IM_DEPTH;
    localparam int FW_LOG  = $clog2(FETCH_WORDS);
    localparam int SEL_W   = (FW_LOG > 0) ? FW_LOG : 1;
    localparam int ROW_W   = IM_DEPTH - FW_LOG;
    localparam int ROWS    = IM_SIZE / FETCH_WORDS;
    localparam int BANK_W  = IM_WIDTH + IM_PAR_BITS;
    localparam logic [ARCH_WIDTH:0] SIZE_X = (ARCH_WIDTH+1)'(IM_SIZE);
    localparam logic [ARCH_WIDTH:0] SPAN_X = (ARCH_WIDTH+1)'(FETCH_WORDS - 1);

    genvar gi;

    // ---------------- request address split and fault check ----------------
    logic [ARCH_WIDTH-1:0] req_idx;
    logic                  req_fault;
    logic [SEL_W-1:0]      req_lo;
    logic [ROW_W-1:0]      req_row;

    assign req_idx   = word_index(req_addr, BASE_ADDR);
    // No wrap: the whole group must fit below the top of memory.
    assign req_fault = misaligned(req_addr[1:0]) || (req_addr < BASE_ADDR) ||
                       (({1'b0, req_idx} + SPAN_X) >= SIZE_X);
    assign req_row   = req_idx[FW_LOG +: ROW_W];

    // ---------------- write address split ----------------
    logic [ARCH_WIDTH-1:0] wr_idx;
    logic                  wr_ok;
    logic [SEL_W-1:0]      wr_sel;
    logic [ROW_W-1:0]      wr_row;
    logic [BANK_W-1:0]     wr_word;

    assign wr_idx = word_index(wr_addr, BASE_ADDR);
    assign wr_ok  = !misaligned(wr_addr[1:0]) && (wr_addr >= BASE_ADDR) &&
                    ({1'b0, wr_idx} < SIZE_X);
    assign wr_row = wr_idx[FW_LOG +: ROW_W];

    generate
        if (FW_LOG > 0) begin : g_sel
            assign req_lo = req_idx[SEL_W-1:0];
            assign wr_sel = wr_idx[SEL_W-1:0];
        end else begin : g_sel_one
            assign req_lo = '0;
            assign wr_sel = '0;
        end
    endgenerate

`ifdef IM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // ---------------- EMPTY/FULL response FSM ----------------
    fetch_state_e     state_q, state_d;
    logic [SEL_W-1:0] lo_q, lo_d;
    logic             afault_q, afault_d;
    logic             accept;

    // Handshake and next state; flush wins over everything else.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        afault_d  = afault_q;
        req_ready = !flush && ((state_q == ST_EMPTY) || rsp_ready);
        accept    = req_valid && req_ready;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d  = ST_FULL;
            lo_d     = req_lo;
            afault_d = req_fault;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State and response-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            lo_q     <= '0;
            afault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            afault_q <= afault_d;
        end
    end

    // ---------------- banks ----------------
    logic [BANK_W-1:0] bank_rd [FETCH_WORDS];

    generate
        for (gi = 0; gi < FETCH_WORDS; gi++) begin : g_bank
            logic [ROW_W-1:0] rd_row;
            logic             bank_we;

            // Banks below the starting bank hold words from the next row.
            assign rd_row  = req_row + ((SEL_W'(gi) < req_lo) ? ROW_W'(1) : ROW_W'(0));
            assign bank_we = wr_en && wr_ok && (wr_sel == SEL_W'(gi));

            im_fetch_banked_bank #(
                .WIDTH (BANK_W),
                .ROWS  (ROWS),
                .ROW_W (ROW_W)
            ) u_bank (
                .clk       (clk),
                .wr_en_i   (bank_we),
                .wr_row_i  (wr_row),
                .wr_data_i (wr_word),
                .rd_en_i   (accept && !req_fault),
                .rd_row_i  (rd_row),
                .rd_data_o (bank_rd[gi])
            );
        end
    endgenerate

    // ---------------- rotation into fetch order ----------------
    logic [FETCH_WORDS*IM_WIDTH-1:0] rot_data;
    logic [FETCH_WORDS-1:0]          word_perr;

    generate
        for (gi = 0; gi < FETCH_WORDS; gi++) begin : g_rot
            logic [SEL_W-1:0] sel;

            assign sel = lo_q + SEL_W'(gi);
            // Word 0 lands in the most significant slot (bit 0 of rsp_data).
            assign rot_data[(FETCH_WORDS-1-gi)*IM_WIDTH +: IM_WIDTH] = bank_rd[sel][IM_WIDTH-1:0];
`ifdef IM_PARITY_EN
            assign word_perr[gi] = ^bank_rd[sel];
`else
            assign word_perr[gi] = 1'b0;
`endif
        end
    endgenerate

    // ---------------- response outputs ----------------
    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_perr  = rsp_valid && !afault_q && (|word_perr);
    assign rsp_fault = rsp_valid && (afault_q || rsp_perr);
    assign rsp_data  = (rsp_valid && !afault_q) ? rot_data : '0;

endmodule

// File: tb/tb_im_fetch_banked.sv
// Scoreboard bench for im_fetch_banked (BASE 0x3000, 2 words/fetch, 1024 words).
module tb_im_fetch_banked;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam int SIZE = 1024;
`ifdef IM_PARITY_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [0:63] rsp_data;
    logic        rsp_fault;
    logic        rsp_perr;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [0:31] wr_data = '0;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic        fault;
        logic        perr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [SIZE];
    bit          flip_m [SIZE];
    bit          full_m = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    im_fetch_banked dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .rsp_perr  (rsp_perr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: a fetch is the two words at the word index, or a fault.
    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        int unsigned idx;
        e.addr  = a;
        e.data  = '0;
        e.fault = 1'b1;
        e.perr  = 1'b0;
        if (a[1:0] == 2'b00 && a >= BASE) begin
            idx = (a - BASE) / 4;
            if (idx + 1 < SIZE) begin
                e.data  = {mem_m[idx], mem_m[idx+1]};
                e.perr  = flip_m[idx] || flip_m[idx+1];
                e.fault = e.perr;
            end
        end
        return e;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        int unsigned idx;
        if (a[1:0] == 2'b00 && a >= BASE) begin
            idx = (a - BASE) / 4;
            if (idx < SIZE) begin
                mem_m[idx] = d;
                flip_m[idx] = 1'b0;
            end
        end
    endtask

    // One clock of stimulus: bookkeeping at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t e;
        bit   ready_m;
        bit   acc;
        @(negedge clk);
        if (rst_n) begin
            ready_m = !flush && (!full_m || rsp_ready);
            check("req_ready", 64'(req_ready), 64'(ready_m));
            check("rsp_valid", 64'(rsp_valid), 64'(full_m));
            acc = req_valid && ready_m;
            if (flush) exp_q.delete();
            if (acc) begin
                e = model_fetch(req_addr);
                exp_q.push_back(e);
            end
            if (wr_en) model_write(wr_addr, wr_data);
            if (flush) full_m = 1'b0;
            else if (acc) full_m = 1'b1;
            else if (rsp_ready) full_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake is compared against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
                check("rsp_perr", 64'(rsp_perr), 64'(e.perr));
                $display("rsp addr=%h data=%h fault=%b perr=%b", e.addr, rsp_data, rsp_fault, rsp_perr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] dir_addr [6];
    logic [63:0] dir_data [6];
    logic        dir_flt  [6];

    initial begin
        dir_addr = '{32'h3008, 32'h300C, 32'h3002, 32'h2FFC, 32'h3FFC, 32'h3FF8};
        dir_data = '{64'hA0000002_A0000003, 64'hA0000003_A0000004, 64'd0, 64'd0, 64'd0,
                     64'hA00003FE_A00003FF};
        dir_flt  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        #2;
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_fault", 64'(rsp_fault), 64'd0);
        check("reset_perr", 64'(rsp_perr), 64'd0);
        check("reset_data", rsp_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_ready", 64'(req_ready), 64'd1);

        // Boot load word i = 0xA0000000 + i
        for (int i = 0; i < SIZE; i++) begin
            wr_en   = 1'b1;
            wr_addr = BASE + 32'(4 * i);
            wr_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        wr_en = 1'b0;

        // Aligned, rotated, faulting and last-in-range fetches back to back
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = dir_addr[i];
            tick();
            check("dir_valid", 64'(rsp_valid), 64'd1);
            check("dir_data", rsp_data, dir_data[i]);
            check("dir_fault", 64'(rsp_fault), 64'(dir_flt[i]));
        end
        req_valid = 1'b0;
        tick();

        // Backpressure: hold for 3 cycles, then back-to-back
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h3010;
        tick();
        req_addr = 32'h3020;
        repeat (3) begin
            tick();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_data", rsp_data, 64'hA0000004_A0000005);
        end
        rsp_ready = 1'b1;
        tick();
        check("b2b_data0", rsp_data, 64'hA0000008_A0000009);
        req_addr = 32'h3028;
        tick();
        check("b2b_data1", rsp_data, 64'hA000000A_A000000B);
        req_valid = 1'b0;
        tick();

        // Same-cycle write returns old data; then new data
        req_valid = 1'b1;
        req_addr  = 32'h3030;
        wr_en     = 1'b1;
        wr_addr   = 32'h3030;
        wr_data   = 32'h1234_5678;
        tick();
        wr_en = 1'b0;
        check("rf_old", rsp_data, 64'hA000000C_A000000D);
        tick();
        check("rf_new", rsp_data, 64'h12345678_A000000D);
        req_valid = 1'b0;

        // Ignored writes: misaligned, below base, past end
        wr_en   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        wr_addr = 32'h3036;
        tick();
        wr_addr = 32'h2FF0;
        tick();
        wr_addr = 32'h4000;
        tick();
        wr_en     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h3034;
        tick();
        check("ign_mis", rsp_data, 64'hA000000D_A000000E);
        req_addr = 32'h3000;
        tick();
        check("ign_top", rsp_data, 64'hA0000000_A0000001);
        req_addr = 32'h3FF0;
        tick();
        check("ign_low", rsp_data, 64'hA00003FC_A00003FD);
        req_valid = 1'b0;
        tick();

        // Flush while FULL with a request pending
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h3040;
        tick();
        flush    = 1'b1;
        req_addr = 32'h3048;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("flush_stay", 64'(rsp_valid), 64'd0);

        // Asynchronous reset mid-transfer
        req_valid = 1'b1;
        req_addr  = 32'h3050;
        tick();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_data", rsp_data, 64'd0);
        exp_q.delete();
        full_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Parity error at word 5
`ifdef IM_PARITY_EN
        dut.g_bank[1].u_bank.mem_q[2][32] = ~dut.g_bank[1].u_bank.mem_q[2][32];
        flip_m[5] = 1'b1;
`endif
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h3014;
        tick();
        check("par_perr", 64'(rsp_perr), 64'(PERR_EXP));
        check("par_fault", 64'(rsp_fault), 64'(PERR_EXP));
        check("par_data", rsp_data, 64'hA0000005_A0000006);
        req_valid = 1'b0;
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            req_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 7) req_addr = BASE + 32'(4 * $urandom_range(0, 1022));
            else if (r == 7) req_addr = BASE + 32'(4 * $urandom_range(0, 1022)) + 32'($urandom_range(1, 3));
            else if (r == 8) req_addr = BASE - 32'(4 * $urandom_range(1, 16));
            else req_addr = BASE + 32'(4 * $urandom_range(1023, 1100));
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            if (flush) rsp_ready = 1'b0;
            wr_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) wr_addr = BASE + 32'($urandom_range(0, 8191));
            else wr_addr = BASE + 32'(4 * $urandom_range(0, 1023));
            wr_data = $urandom();
            tick();
        end

        // Drain
        flush     = 1'b0;
        wr_en     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
